regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with an integrated busy-bit scoreboard, serving the decode and writeback stages of the pipelined RV32I core. Provides NRD combinational read ports and NWR clocked write ports. x0 is hardwired to zero. Per-register pending bits let decode stall on RAW hazards without a separate scoreboard block.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- ADDR_W, $clog2(NREGS), register index width
- NRD, 2, number of read ports (1..4)
- NWR, 2, number of write ports (1..2)

- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_rnum  in  NRD×ADDR_W  read port register indices
- o_rd  out  NRD×DATA_W  read data, combinational
- o_rbusy  out  NRD  busy bit of each read port's register, combinational
- i_wen  in  NWR  write enables
- i_wnum  in  NWR×ADDR_W  write register indices
- i_wd  in  NWR×DATA_W  write data
- i_iss_en  in  1  issue strobe: mark i_iss_rd pending
- i_iss_rd  in  ADDR_W  destination register being issued
- o_wcollide  out  1  registered: previous cycle had ≥2 write ports enabled on the same nonzero index

## Operation
- Storage: regs[1..NREGS-1] of DATA_W bits. No flop for index 0.
- Read: o_rd[p] = 0 if i_rnum[p]==0, else regs[i_rnum[p]] (bypass rules in Configuration).
- Write: on posedge, for each port w with i_wen[w] and i_wnum[w]!=0, regs[i_wnum[w]] <= i_wd[w]. Writes to x0 are discarded silently.
- Same-index write conflict: the highest-numbered port wins. o_wcollide = 1 for exactly the following cycle.
- Scoreboard: busy[NREGS-1:1], busy[0] constant 0.
  - Issue sets busy[i_iss_rd] when i_iss_en is high and i_iss_rd != 0.
  - Any accepted write clears busy[i_wnum[w]].
  - Issue and write to the same register in the same cycle: issue wins, so busy ends at 1 and the new producer is pending.
  - A write to a non-busy register is legal. Data updates and busy stays 0.
- o_rbusy[p] = busy[i_rnum[p]], using the current (pre-edge) state.
- Reset (asynchronous, any time, including mid-write): all regs = 0, all busy = 0, o_wcollide = 0. Writes coincident with reset assertion are lost.

## Timing
- Read latency 0 cycles (combinational from i_rnum and storage).
- Write latency 1 edge: the value is visible on the read ports in the cycle after i_wen, or in the same cycle with bypass.
- Busy set/clear visible on o_rbusy in the cycle after the issue or write edge.
- o_wcollide is registered. It is high during cycle N+1 for a collision in cycle N.
- Output reset values: o_rd = 0 for all ports, o_rbusy = 0, o_wcollide = 0.
- No handshake backpressure. The caller guarantees at most one issue per cycle.

## Configuration
- RF_BYPASS_EN defined: write-first forwarding.
  - If port w writes index k != 0 this cycle and i_rnum[p]==k, then o_rd[p] = i_wd[w], using the winning port on a conflict.
  - o_rbusy[p] is also forced to 0 for that port, unless i_iss_en targets k in the same cycle.
- RF_BYPASS_EN undefined: read-before-write.
  - A same-cycle read returns the value stored before the edge, and o_rbusy reflects pre-edge busy.
  - The pipeline must then handle writeback→decode forwarding externally.

## Test plan
- Reset then read all 32 indices on both ports -> all 0, o_rbusy=0. Assert i_rstn low mid-burst after writing x5=0xDEADBEEF -> x5 reads 0 immediately.
- Write x0=0xFFFFFFFF on port 0, read x0 next cycle -> 0. Issue on x0 -> o_rbusy stays 0.
- Port 0 writes x7=0x11, port 1 writes x7=0x22 in the same cycle -> x7 reads 0x22 next cycle, o_wcollide=1 for exactly one cycle.
- Issue x3 in cycle 0 -> o_rbusy=1 when reading x3 in cycle 1. Write x3=0x55 in cycle 2 -> busy=0 and data 0x55 in cycle 3. Issue x3 and write x3 in the same cycle -> busy stays 1.
- Write x9=0xA5A5 and read x9 in the same cycle: with RF_BYPASS_EN -> 0xA5A5. Without it -> the previous x9 value (0 after reset).
- Parameter sweep NREGS=16, DATA_W=64, NRD=4, NWR=1: write 0x0123456789ABCDEF to x15, read on all four ports -> identical value on every port.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard; x0 reads as zero.
// Reads are combinational, writes land on the clock edge. Define RF_BYPASS_EN for write-first forwarding.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [NRD-1:0][ADDR_W-1:0]    i_rnum,
    output logic [NRD-1:0][DATA_W-1:0]    o_rd,
    output logic [NRD-1:0]                o_rbusy,
    input  logic [NWR-1:0]                i_wen,
    input  logic [NWR-1:0][ADDR_W-1:0]    i_wnum,
    input  logic [NWR-1:0][DATA_W-1:0]    i_wd,
    input  logic                          i_iss_en,
    input  logic [ADDR_W-1:0]             i_iss_rd,
    output logic                          o_wcollide
);

    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    logic [DATA_W-1:0] regs_d [1:NREGS-1];
    logic [NREGS-1:1]  busy_q;
    logic [NREGS-1:1]  busy_d;
    logic              wcollide_q;
    logic              wcollide_d;
    logic [NWR-1:0]    wacc;
    logic              iss_acc;

    always_comb begin
        for (int w = 0; w < NWR; w++) begin
            wacc[w] = i_wen[w] && (i_wnum[w] != '0);
        end
        iss_acc = i_iss_en && (i_iss_rd != '0);
    end

    // Ascending port order means the highest-numbered port wins a same-index
    // conflict; issue is applied last so a new producer stays pending.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        wcollide_d = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wacc[w]) begin
                regs_d[i_wnum[w]] = i_wd[w];
                busy_d[i_wnum[w]] = 1'b0;
            end
        end
        if (iss_acc) begin
            busy_d[i_iss_rd] = 1'b1;
        end
        for (int a = 0; a < NWR; a++) begin
            for (int b = a + 1; b < NWR; b++) begin
                if (wacc[a] && wacc[b] && (i_wnum[a] == i_wnum[b])) begin
                    wcollide_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            wcollide_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            wcollide_q <= wcollide_d;
        end
    end

`ifdef RF_BYPASS_EN
    logic [NRD-1:0] byp_hit;
`endif

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            o_rd[p]    = '0;
            o_rbusy[p] = 1'b0;
            if (i_rnum[p] != '0) begin
                o_rd[p]    = regs_q[i_rnum[p]];
                o_rbusy[p] = busy_q[i_rnum[p]];
            end
`ifdef RF_BYPASS_EN
            byp_hit[p] = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (wacc[w] && (i_wnum[w] == i_rnum[p])) begin
                    o_rd[p]    = i_wd[w];
                    byp_hit[p] = 1'b1;
                end
            end
            // A same-cycle issue to the forwarded register means a newer producer is pending.
            if (byp_hit[p] && !(iss_acc && (i_iss_rd == i_rnum[p]))) begin
                o_rbusy[p] = 1'b0;
            end
`endif
        end
    end

    assign o_wcollide = wcollide_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed table-driven bench for regfile_mp: default 2R/2W instance plus a 4R/1W 64-bit sweep instance.
module tb_regfile_mp;

    logic i_clk = 1'b0;
    logic i_rstn = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [1:0][4:0]  rnum;
    logic [1:0][31:0] rd;
    logic [1:0]       rbusy;
    logic [1:0]       wen;
    logic [1:0][4:0]  wnum;
    logic [1:0][31:0] wd;
    logic             iss_en;
    logic [4:0]       iss_rd;
    logic             wcollide;

    regfile_mp u_dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_rnum     (rnum),
        .o_rd       (rd),
        .o_rbusy    (rbusy),
        .i_wen      (wen),
        .i_wnum     (wnum),
        .i_wd       (wd),
        .i_iss_en   (iss_en),
        .i_iss_rd   (iss_rd),
        .o_wcollide (wcollide)
    );

    logic [3:0][3:0]  s_rnum;
    logic [3:0][63:0] s_rd;
    logic [3:0]       s_rbusy;
    logic [0:0]       s_wen;
    logic [0:0][3:0]  s_wnum;
    logic [0:0][63:0] s_wd;
    logic             s_iss_en;
    logic [3:0]       s_iss_rd;
    logic             s_wcollide;

    regfile_mp #(.DATA_W(64), .NREGS(16), .NRD(4), .NWR(1)) u_sweep (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_rnum     (s_rnum),
        .o_rd       (s_rd),
        .o_rbusy    (s_rbusy),
        .i_wen      (s_wen),
        .i_wnum     (s_wnum),
        .i_wd       (s_wd),
        .i_iss_en   (s_iss_en),
        .i_iss_rd   (s_iss_rd),
        .o_wcollide (s_wcollide)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wn0;
        logic [31:0] wd0;
        logic [4:0]  wn1;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  issrd;
        logic [4:0]  rn0;
        logic [4:0]  rn1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        ec;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] wen_i, input logic [4:0] wn0_i, input logic [31:0] wd0_i,
                                input logic [4:0] wn1_i, input logic [31:0] wd1_i, input logic iss_i,
                                input logic [4:0] issrd_i, input logic [4:0] rn0_i, input logic [4:0] rn1_i,
                                input logic [31:0] e0_i, input logic [31:0] e1_i, input logic [1:0] eb_i,
                                input logic ec_i);
        vec_t v;
        v.wen = wen_i; v.wn0 = wn0_i; v.wd0 = wd0_i; v.wn1 = wn1_i; v.wd1 = wd1_i;
        v.iss = iss_i; v.issrd = issrd_i; v.rn0 = rn0_i; v.rn1 = rn1_i;
        v.e0 = e0_i; v.e1 = e1_i; v.eb = eb_i; v.ec = ec_i;
        return v;
    endfunction

    task automatic idle();
        wen = '0; wnum = '0; wd = '0; iss_en = 1'b0; iss_rd = '0; rnum = '0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    vec_t vt[17];

    initial begin
        idle();
        s_rnum = '0; s_wen = '0; s_wnum = '0; s_wd = '0; s_iss_en = 1'b0; s_iss_rd = '0;
        // Each row: inputs held for one cycle, outputs checked before that cycle's edge.
        vt[0]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 5, 31, 0, 0, 2'b00, 0);
        vt[1]  = mk(2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 1, 2, 0, 0, 2'b00, 0);
        vt[2]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 0, 32'h22, 0, 2'b00, 1);
        vt[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 32'h22, 32'h22, 2'b00, 0);
        vt[4]  = mk(2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 7, 0, 32'h22, 2'b00, 0);
        vt[5]  = mk(2'b00, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 2'b00, 0);
        vt[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 2'b01, 0);
        vt[7]  = mk(2'b10, 0, 0, 3, 32'h55, 0, 0, 7, 1, 32'h22, 0, 2'b00, 0);
        vt[8]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 32'h55, 32'h55, 2'b00, 0);
        vt[9]  = mk(2'b01, 3, 32'h66, 0, 0, 1, 3, 7, 7, 32'h22, 32'h22, 2'b00, 0);
        vt[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 7, 32'h66, 32'h22, 2'b01, 0);
        vt[11] = mk(2'b11, 10, 32'hAAAA, 11, 32'hBBBB, 0, 0, 7, 3, 32'h22, 32'h66, 2'b10, 0);
        vt[12] = mk(2'b00, 0, 0, 0, 0, 0, 0, 10, 11, 32'hAAAA, 32'hBBBB, 2'b00, 0);
        vt[13] = mk(2'b11, 3, 32'h77, 10, 32'hCCCC, 0, 0, 7, 7, 32'h22, 32'h22, 2'b00, 0);
        vt[14] = mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 10, 32'h77, 32'hCCCC, 2'b00, 0);
        vt[15] = mk(2'b11, 0, 32'h1, 0, 32'h2, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        vt[16] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h77, 2'b00, 0);

        #12;
        chk("reset_wcollide", {63'd0, wcollide}, 64'd0);
        for (int r = 0; r < 32; r++) begin
            rnum[0] = r[4:0];
            rnum[1] = 5'(31 - r);
            #1;
            if (rd != '0 || rbusy != '0) begin
                chk($sformatf("reset_read_x%0d", r), {rbusy, rd}, 64'd0);
            end else begin
                checks++;
            end
        end
        i_rstn = 1'b1;
        tick();

        foreach (vt[i]) begin
            wen = vt[i].wen; wnum[0] = vt[i].wn0; wd[0] = vt[i].wd0;
            wnum[1] = vt[i].wn1; wd[1] = vt[i].wd1;
            iss_en = vt[i].iss; iss_rd = vt[i].issrd;
            rnum[0] = vt[i].rn0; rnum[1] = vt[i].rn1;
            #1;
            chk($sformatf("v%0d_rd0", i), {32'd0, rd[0]}, {32'd0, vt[i].e0});
            chk($sformatf("v%0d_rd1", i), {32'd0, rd[1]}, {32'd0, vt[i].e1});
            chk($sformatf("v%0d_rbusy", i), {62'd0, rbusy}, {62'd0, vt[i].eb});
            chk($sformatf("v%0d_wcollide", i), {63'd0, wcollide}, {63'd0, vt[i].ec});
            tick();
        end
        idle();

        // Same-cycle write and read of x9.
        wen = 2'b01; wnum[0] = 5'd9; wd[0] = 32'hA5A5; rnum[0] = 5'd9; rnum[1] = 5'd9;
        #1;
`ifdef RF_BYPASS_EN
        chk("samecyc_x9", {32'd0, rd[0]}, 64'hA5A5);
`else
        chk("samecyc_x9", {32'd0, rd[0]}, 64'h0);
`endif
        tick();
        wen = '0;
        #1;
        chk("after_x9", {32'd0, rd[1]}, 64'hA5A5);

        // Busy forwarding corner: write to a pending register while reading it.
        iss_en = 1'b1; iss_rd = 5'd12;
        tick();
        iss_en = 1'b0;
        wen = 2'b10; wnum[1] = 5'd12; wd[1] = 32'h1212; rnum[0] = 5'd12;
        #1;
`ifdef RF_BYPASS_EN
        chk("wb_busy_x12", {63'd0, rbusy[0]}, 64'd0);
        chk("wb_data_x12", {32'd0, rd[0]}, 64'h1212);
`else
        chk("wb_busy_x12", {63'd0, rbusy[0]}, 64'd1);
        chk("wb_data_x12", {32'd0, rd[0]}, 64'h0);
`endif
        tick();
        wen = '0;
        #1;
        chk("post_busy_x12", {63'd0, rbusy[0]}, 64'd0);
        chk("post_data_x12", {32'd0, rd[0]}, 64'h1212);

        // Parameter sweep instance: x15 visible on all four ports.
        s_wen = 1'b1; s_wnum[0] = 4'd15; s_wd[0] = 64'h0123456789ABCDEF;
        tick();
        s_wen = 1'b0;
        for (int p = 0; p < 4; p++) s_rnum[p] = 4'd15;
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("sweep_rd%0d", p), s_rd[p], 64'h0123456789ABCDEF);
        chk("sweep_rbusy", {60'd0, s_rbusy}, 64'd0);
        chk("sweep_wcollide", {63'd0, s_wcollide}, 64'd0);

        // Asynchronous reset mid-burst clears data and busy immediately.
        wen = 2'b01; wnum[0] = 5'd5; wd[0] = 32'hDEADBEEF; iss_en = 1'b1; iss_rd = 5'd6;
        tick();
        wen = '0; iss_en = 1'b0; rnum[0] = 5'd5; rnum[1] = 5'd6;
        #1;
        chk("pre_rst_x5", {32'd0, rd[0]}, 64'hDEADBEEF);
        chk("pre_rst_busy6", {63'd0, rbusy[1]}, 64'd1);
        wen = 2'b01; wnum[0] = 5'd5; wd[0] = 32'h1234;
        #1;
        i_rstn = 1'b0;
        #1;
        wen = '0;
        #1;
        chk("rst_x5", {32'd0, rd[0]}, 64'd0);
        chk("rst_busy", {62'd0, rbusy}, 64'd0);
        chk("rst_sweep_x15", s_rd[0], 64'd0);
        tick();
        #2;
        i_rstn = 1'b1;
        tick();
        chk("post_rst_x5", {32'd0, rd[0]}, 64'd0);
        chk("post_rst_wcollide", {63'd0, wcollide}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
